// File: rtl/uart_rx_frame_parser.sv
// uart_rx_frame_parser
// Command-frame controller behind the UART byte receiver. Assembles
// HEAD0 HEAD1 ADDR LEN payload CSUM frames from received bytes, buffers the
// payload and, only when the checksum matches, replays it as sequential
// register writes. Bad, oversized or stalled frames are dropped with a
// frame_err pulse.
//
// Byte interface: the receiver has no ready path. A rising edge on byte_irq
// means one new byte, and byte_data is sampled in that same cycle. A byte
// that lands while a frame is being written out is parked in a one-entry
// hold register and parsed in the first cycle after the write-out ends.
// Write interface: wr_en is a one-cycle strobe per byte with no back-pressure.
// wr_addr/wr_data keep their last values while wr_en is low.
module uart_rx_frame_parser #(
  parameter int          MAX_LEN        = 16,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000,
  parameter logic [7:0]  HEAD0          = 8'h55,
  parameter logic [7:0]  HEAD1          = 8'hAA
) (
  input  logic       clk_100M,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_irq,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_H1    = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_LEN   = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_FLUSH = 3'd6;

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  // The counter restarts at 0 in the cycle after a byte, so matching
  // TIMEOUT_CYCLES-2 puts the frame_err pulse exactly TIMEOUT_CYCLES cycles
  // after the last byte.
  localparam logic [31:0] TMO_LAST  = (TIMEOUT_CYCLES > 32'd1) ?
                                      (TIMEOUT_CYCLES - 32'd2) : 32'd0;

  logic [2:0]    state;
  logic          byte_irq_q;
  logic          hold_valid;
  logic [7:0]    hold_data;
  logic [7:0]    addr;
  logic [7:0]    len;
  logic [7:0]    sum;
  logic [7:0]    idx;
  logic [31:0]   tmo_cnt;
  logic [7:0]    buf_mem [MAX_LEN];

  logic          new_byte;
  logic          fire_hold;
  logic          in_valid;
  logic [7:0]    in_byte;
  logic          in_frame;
  logic          tmo_hit;
  logic [AW-1:0] buf_idx;

  assign new_byte  = byte_irq & ~byte_irq_q;
  assign fire_hold = hold_valid & (state != S_FLUSH);
  assign in_valid  = fire_hold | (new_byte & (state != S_FLUSH));
  assign in_byte   = fire_hold ? hold_data : byte_data;
  assign in_frame  = (state != S_IDLE) && (state != S_FLUSH);
  assign tmo_hit   = in_frame & ~in_valid & (tmo_cnt == TMO_LAST);
  assign buf_idx   = idx[AW-1:0];
  assign busy      = (state != S_IDLE);

  // Edge detect on byte_irq and parking of bytes that arrive during write-out.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      byte_irq_q <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= 8'h00;
    end else begin
      byte_irq_q <= byte_irq;
      if (new_byte && ((state == S_FLUSH) || fire_hold)) begin
        hold_valid <= 1'b1;
        hold_data  <= byte_data;
      end else if (fire_hold) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // Inter-byte timeout counter, only running while a frame is being received.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 32'd0;
    end else if (!in_frame || in_valid) begin
      tmo_cnt <= 32'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // Payload buffer; never cleared, only overwritten by the next frame.
  always_ff @(posedge clk_100M) begin
    if (in_valid && (state == S_DATA)) begin
      buf_mem[buf_idx] <= in_byte;
    end
  end

  // Frame parser and write-out sequencer with registered outputs.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= 8'h00;
      len       <= 8'h00;
      sum       <= 8'h00;
      idx       <= 8'h00;
      wr_en     <= 1'b0;
      wr_addr   <= 8'h00;
      wr_data   <= 8'h00;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (tmo_hit) begin
        frame_err <= 1'b1;
        state     <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid && (in_byte == HEAD0)) state <= S_H1;
          end
          S_H1: begin
            if (in_valid) begin
              if (in_byte == HEAD1)      state <= S_ADDR;
              else if (in_byte == HEAD0) state <= S_H1;
              else                       state <= S_IDLE;
            end
          end
          S_ADDR: begin
            if (in_valid) begin
              addr  <= in_byte;
              sum   <= in_byte;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (in_valid) begin
              len <= in_byte;
              sum <= sum + in_byte;
              idx <= 8'h00;
              if (in_byte > MAX_LEN_B) begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
              end else if (in_byte == 8'h00) begin
                state <= S_CSUM;
              end else begin
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (in_valid) begin
              sum <= sum + in_byte;
              idx <= idx + 8'd1;
              if ((idx + 8'd1) == len) state <= S_CSUM;
            end
          end
          S_CSUM: begin
            if (in_valid) begin
              if (in_byte == sum) begin
                state <= S_FLUSH;
                // Issue the first write straight away so it appears one
                // cycle after the checksum byte.
                if (len != 8'h00) begin
                  wr_en   <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= buf_mem[0];
                  idx     <= 8'd1;
                end else begin
                  idx <= 8'h00;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= S_IDLE;
              end
            end
          end
          S_FLUSH: begin
            if (idx != len) begin
              wr_en   <= 1'b1;
              wr_addr <= addr + idx;
              wr_data <= buf_mem[buf_idx];
              idx     <= idx + 8'd1;
            end else begin
              frame_ok <= 1'b1;
              state    <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb_uart_rx_frame_parser
// Directed frames into uart_rx_frame_parser. A byte-list frame model predicts
// the cycle of every write, frame_ok and frame_err; a per-cycle compare
// process checks the DUT against it, and literal write lists pin each test.
module tb_uart_rx_frame_parser;

  localparam int         TMO       = 1000;
  localparam int         MAX_LEN   = 16;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  // ---------------- clock / reset ----------------
  logic       clk_100M  = 1'b0;
  logic       rst_n     = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       byte_irq  = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic       busy;

  always #5 clk_100M = ~clk_100M;

  uart_rx_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (32'(TMO)),
    .HEAD0          (8'h55),
    .HEAD1          (8'hAA)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_irq  (byte_irq),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .busy      (busy)
  );

  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- frame model ----------------
  typedef struct {
    int          cyc;
    logic [1:0]  kind;   // 0 write, 1 frame_ok, 2 frame_err
    logic [15:0] ad;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fb[$];         // bytes of the frame currently being received
  int         mdl_last = 0;  // cycle the last in-frame byte was parsed
  int         csum_cyc = -100;
  int         ok_cyc   = -100;

  function automatic void push_exp(input int c, input logic [1:0] k, input logic [15:0] ad);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.ad   = ad;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    fb.delete();
    exp_q.delete();
    csum_cyc = -100;
    ok_cyc   = -100;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input int t);
    int         eff;
    int         n;
    int         len;
    int         tail;
    logic [7:0] s;
    logic [7:0] a;
    // A byte landing while a good frame is being written out is parsed on
    // the frame_ok cycle.
    eff = (t > csum_cyc && t < ok_cyc) ? ok_cyc : t;
    if (fb.size() == 0) begin
      if (b == 8'h55) fb.push_back(b);
    end else if (fb.size() == 1) begin
      if (b == 8'hAA) fb.push_back(b);
      else if (b != 8'h55) fb.delete();
    end else begin
      fb.push_back(b);
      n = fb.size();
      if (n == 4 && b > MAX_LEN_B) begin
        push_exp(eff + 1, 2'd2, 16'h0);
        fb.delete();
      end else if (n >= 5 && n == 5 + int'(fb[3])) begin
        len = int'(fb[3]);
        s = 8'h00;
        for (int i = 2; i <= n - 2; i++) s = s + fb[i];
        if (s == b) begin
          for (int i = 0; i < len; i++) begin
            a = fb[2] + 8'(i);
            push_exp(eff + 1 + i, 2'd0, {a, fb[4 + i]});
          end
          tail     = (len > 0) ? len : 1;
          csum_cyc = eff;
          ok_cyc   = eff + 1 + tail;
          push_exp(ok_cyc, 2'd1, 16'h0);
        end else begin
          push_exp(eff + 1, 2'd2, 16'h0);
        end
        fb.delete();
      end
    end
    mdl_last = eff;
  endfunction

  // ---------------- scoreboard / compare ----------------
  logic [15:0] obs_wr_q[$];
  int          obs_ok       = 0;
  int          obs_err      = 0;
  int          last_err_cyc = -1;
  logic        ew, eo, ee;
  logic [15:0] ead;

  always @(negedge clk_100M) begin
    if (rst_n) begin
      ew = 1'b0; eo = 1'b0; ee = 1'b0; ead = 16'h0;
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc == cyc) begin
          case (exp_q[i].kind)
            2'd0: begin ew = 1'b1; ead = exp_q[i].ad; end
            2'd1: eo = 1'b1;
            default: ee = 1'b1;
          endcase
          exp_q.delete(i);
        end
      end
      if (fb.size() > 0 && cyc == mdl_last + TMO) begin
        ee = 1'b1;
        fb.delete();
      end
      chk("wr_en", 32'(wr_en), 32'(ew));
      if (ew) begin
        chk("wr_addr", 32'(wr_addr), 32'(ead[15:8]));
        chk("wr_data", 32'(wr_data), 32'(ead[7:0]));
      end
      chk("frame_ok", 32'(frame_ok), 32'(eo));
      chk("frame_err", 32'(frame_err), 32'(ee));
      if (wr_en) obs_wr_q.push_back({wr_addr, wr_data});
      if (frame_ok) obs_ok++;
      if (frame_err) begin
        obs_err++;
        last_err_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  int          last_tx = 0;
  logic [15:0] lit_q[$];

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk_100M);
    byte_data = b;
    byte_irq  = 1'b1;
    last_tx   = cyc;
    model_byte(b, cyc);
    @(negedge clk_100M);
    byte_irq = 1'b0;
    repeat (gap) @(negedge clk_100M);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_100M);
  endtask

  function automatic void lit(input logic [15:0] v);
    lit_q.push_back(v);
  endfunction

  task automatic check_log(input string name, input int n_ok, input int n_err);
    chk({name, "_nwr"}, 32'(obs_wr_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++) begin
      if (i < obs_wr_q.size()) chk({name, "_wr"}, {16'h0, obs_wr_q[i]}, {16'h0, lit_q[i]});
    end
    chk({name, "_nok"}, 32'(obs_ok), 32'(n_ok));
    chk({name, "_nerr"}, 32'(obs_err), 32'(n_err));
    obs_wr_q.delete();
    lit_q.delete();
    obs_ok  = 0;
    obs_err = 0;
  endtask

  logic [7:0] f_good [8]  = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h79};
  logic [7:0] f_bad  [8]  = '{8'h55, 8'hAA, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h78};
  logic [7:0] f_over [7]  = '{8'h3C, 8'h55, 8'h12, 8'h55, 8'hAA, 8'h00, 8'h11};
  logic [7:0] f_zero [5]  = '{8'h55, 8'hAA, 8'h05, 8'h00, 8'h05};
  logic [7:0] f_wrap [9]  = '{8'h55, 8'h55, 8'hAA, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'h07};
  logic [7:0] f_after[6]  = '{8'h55, 8'hAA, 8'h40, 8'h01, 8'h5A, 8'h9B};
  logic [7:0] f_b2b_a[6]  = '{8'h55, 8'hAA, 8'h20, 8'h02, 8'h01, 8'h02};
  logic [7:0] f_b2b_b[5]  = '{8'hAA, 8'h30, 8'h01, 8'h09, 8'h3A};
  logic [7:0] f_part [6]  = '{8'h55, 8'hAA, 8'h50, 8'h04, 8'h01, 8'h02};
  logic [7:0] f_rst  [7]  = '{8'h55, 8'hAA, 8'h60, 8'h02, 8'h0A, 8'h0B, 8'h77};

  // ---------------- test sequence ----------------
  int t0;

  initial begin
    rst_n = 1'b0;
    idle(3);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    idle(2);

    // Good frame.
    foreach (f_good[i]) send_byte(f_good[i], 3);
    idle(10);
    lit(16'h1011); lit(16'h1122); lit(16'h1233);
    check_log("good", 1, 0);

    // Bad checksum.
    foreach (f_bad[i]) send_byte(f_bad[i], 3);
    t0 = last_tx;
    idle(10);
    chk("bad_csum_err_cyc", 32'(last_err_cyc), 32'(t0 + 1));
    check_log("bad_csum", 0, 1);

    // Junk in IDLE, header abort without error, oversize, then zero length.
    foreach (f_over[i]) send_byte(f_over[i], 3);
    t0 = last_tx;
    idle(6);
    chk("oversize_err_cyc", 32'(last_err_cyc), 32'(t0 + 1));
    foreach (f_zero[i]) send_byte(f_zero[i], 3);
    idle(10);
    check_log("over_zero", 1, 1);

    // Header resync and address wrap.
    foreach (f_wrap[i]) send_byte(f_wrap[i], 3);
    idle(10);
    lit(16'hFE01); lit(16'hFF02); lit(16'h0003);
    check_log("wrap", 1, 0);

    // Timeout after ADDR, then a good frame.
    send_byte(8'h55, 3);
    send_byte(8'hAA, 3);
    send_byte(8'h10, 0);
    t0 = last_tx;
    idle(500);
    chk("tmo_busy_waiting", 32'(busy), 32'd1);
    idle(510);
    chk("tmo_err_cyc", 32'(last_err_cyc), 32'(t0 + TMO));
    chk("tmo_busy_after", 32'(busy), 32'd0);
    check_log("timeout", 0, 1);
    foreach (f_after[i]) send_byte(f_after[i], 3);
    idle(10);
    lit(16'h405A);
    check_log("after_tmo", 1, 0);

    // Back-to-back: next HEAD0 arrives during write-out and is held.
    foreach (f_b2b_a[i]) send_byte(f_b2b_a[i], 3);
    send_byte(8'h25, 0);
    send_byte(8'h55, 3);
    foreach (f_b2b_b[i]) send_byte(f_b2b_b[i], 3);
    idle(10);
    lit(16'h2001); lit(16'h2102); lit(16'h3009);
    check_log("b2b", 2, 0);

    // Reset mid-DATA, then a good frame.
    foreach (f_part[i]) send_byte(f_part[i], 3);
    chk("busy_mid_frame", 32'(busy), 32'd1);
    @(negedge clk_100M);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk_100M);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_wr_data", 32'(wr_data), 32'd0);
    chk("mid_rst_frame_ok", 32'(frame_ok), 32'd0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    idle(2);
    foreach (f_rst[i]) send_byte(f_rst[i], 3);
    idle(10);
    lit(16'h600A); lit(16'h610B);
    check_log("post_rst", 1, 0);

    idle(20);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_parser.md
Name: uart_rx_frame_parser

Overview:
- Command-frame controller behind the UART byte receiver.
- Consumes received bytes (rising edge of the receiver's completion flag plus its data byte) and assembles frames: header, address, length, payload, checksum.
- Buffers the payload and, only on a valid checksum, issues it as sequential register writes to the control-register bank.
- Malformed, oversized or stalled frames are discarded and reported.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (1..255); sets buffer depth.
- TIMEOUT_CYCLES, 32'd100000, clk_100M cycles allowed between bytes inside a frame (1 ms).
- HEAD0, 8'h55, first header byte.
- HEAD1, 8'hAA, second header byte.

Ports:
- clk_100M  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset.
- byte_data  input  8  received byte; valid when byte_irq rises.
- byte_irq  input  1  byte-received flag; rising edge means one new byte.
- wr_en  output  1  register write strobe, one cycle per byte.
- wr_addr  output  8  register write address.
- wr_data  output  8  register write data.
- frame_ok  output  1  one-cycle pulse when a frame has been fully written.
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous, active-low, on clock clk_100M.
  - All outputs reset to 0. State resets to IDLE. Edge-detect register, counters, checksum and hold flag reset to 0.
- Byte capture:
  - new_byte = byte_irq & ~byte_irq_q, where byte_irq_q is byte_irq delayed one cycle.
  - byte_data is sampled in the same cycle new_byte is high.
  - A byte arriving during FLUSH is stored in a one-entry hold register and processed in the first cycle after FLUSH exits.
- Frame format: HEAD0, HEAD1, ADDR, LEN, LEN payload bytes, CSUM.
  - CSUM = (ADDR + LEN + sum of payload) mod 256.
- FSM transitions, each taken on new_byte:
  - IDLE: byte==HEAD0 -> H1; any other byte is ignored.
  - H1: byte==HEAD1 -> ADDR. byte==HEAD0 -> stay in H1 (resync). Otherwise -> IDLE, with no frame_err.
  - ADDR: latch addr; sum=byte -> LEN.
  - LEN:
    - byte > MAX_LEN -> frame_err, then IDLE.
    - byte==0 -> CSUM.
    - Otherwise -> DATA.
    - In all cases sum += byte and idx=0.
  - DATA: buf[idx]=byte; sum += byte; idx++. After the LEN-th byte -> CSUM.
  - CSUM:
    - byte==sum -> FLUSH.
    - Mismatch -> frame_err, then IDLE.
  - FLUSH:
    - One write per cycle for i=0..LEN-1: wr_en=1, wr_addr=(addr+i) mod 256 (wraps FF->00), wr_data=buf[i].
    - The cycle after the last write (or the cycle after entering FLUSH when LEN=0): frame_ok=1, then IDLE.
- Latency:
  - First wr_en is asserted 1 cycle after the cycle in which the CSUM new_byte is seen.
  - frame_err is asserted 1 cycle after the offending new_byte.
- Timeout:
  - Counter runs in H1/ADDR/LEN/DATA/CSUM and clears on every new_byte.
  - Reaching TIMEOUT_CYCLES -> frame_err pulse, then IDLE; partial frame discarded, no writes.
  - Counter is held at 0 in IDLE and FLUSH.
- No writes ever occur for a discarded frame; buffer contents are not cleared, only overwritten.
- frame_ok and frame_err are never high in the same cycle.
- wr_addr and wr_data hold their last values when wr_en=0.
- Reset mid-frame or mid-FLUSH: writes stop immediately and no pulse is issued.

Test Plan:
- Good frame: 55 AA 10 03 11 22 33 79 -> wr_en on 3 consecutive cycles (10,11)(11,22)(12,33), then frame_ok one cycle later, frame_err never.
- Bad checksum: 55 AA 10 03 11 22 33 78 -> frame_err one cycle after the last byte, zero wr_en.
- Oversize and zero length:
  - 55 AA 00 11 -> frame_err after the LEN byte; following 55 AA 05 00 05 -> frame_ok, no writes.
- Resync and address wrap: 55 55 AA FE 03 01 02 03 07 -> writes (FE,01)(FF,02)(00,03), then frame_ok.
- Timeout with TIMEOUT_CYCLES=1000: 55 AA 10, then idle -> frame_err exactly 1000 cycles after the last new_byte, busy drops. A subsequent good frame is accepted.
- Back-to-back and reset:
  - A byte edge during FLUSH is held and parsed as HEAD0 of the next frame.
  - rst_n low mid-DATA -> all outputs 0 and busy=0; after release, a good frame completes normally.
